// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the parametrised register file.
package reg_file_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 4;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_t;

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Clear sequencer: sweeps registers 1..NREGS-1 to zero after reset or on request,
// then holds RUN; also owns the sticky write-while-busy error flag.
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic              clr_req,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              wr_err
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = '1;

    rf_state_t         state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic              wr_err_q, wr_err_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RF_CLEAR;
            cnt      <= FIRST_IDX;
            wr_err_q <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            wr_err_q <= wr_err_next;
        end
    end

    // Exit is decided on the last index before any increment, so cnt never wraps to 0.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        wr_err_next = wr_err_q;
        ready       = 1'b0;
        clr_we      = 1'b0;
        clr_addr    = cnt;
        case (state)
            RF_CLEAR: begin
                clr_we = 1'b1;
                if (write_enable) begin
                    wr_err_next = 1'b1;
                end
                if (cnt == LAST_IDX) begin
                    state_next = RF_RUN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RF_RUN: begin
                ready = 1'b1;
                if (clr_req) begin
                    state_next = RF_CLEAR;
                    cnt_next   = FIRST_IDX;
                end
            end
            default: begin
                state_next = RF_CLEAR;
                cnt_next   = FIRST_IDX;
            end
        endcase
    end

    assign wr_err = wr_err_q;

endmodule

// File: rtl/reg_file_p.sv
// Parametrised CPU register file: two read ports with optional write bypass,
// register 0 reads as zero, mirrored output register, built-in clear sweep.
module reg_file_p
    import reg_file_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int OUT_IDX = (2 ** ADDR_W) - 1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD,
    input  logic              write_enable,
    input  logic              clr_req,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] cpu_out,
    output logic              ready,
    output logic              wr_err
);

    localparam int                NREGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(OUT_IDX);

    logic [DATA_W-1:0] rf [NREGS];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;

    reg_file_clear_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clear_fsm (
        .clk         (clk),
        .reset       (reset),
        .write_enable(write_enable),
        .clr_req     (clr_req),
        .ready       (ready),
        .clr_we      (clr_we),
        .clr_addr    (clr_addr),
        .wr_err      (wr_err)
    );

    // The sweep owns the write port while clearing; normal writes only land in RUN.
    always_comb begin
        mem_we   = clr_we | (ready & write_enable & (WA != '0));
        mem_addr = clr_we ? clr_addr : WA;
        mem_wd   = clr_we ? '0 : WD;
    end

    always_ff @(posedge clk) begin
        if (mem_we && (mem_addr != '0)) begin
            rf[mem_addr] <= mem_wd;
        end
    end

    always_comb begin
        RD1 = '0;
        if (ready && (RA1 != '0)) begin
            if (BYPASS && write_enable && (WA == RA1)) begin
                RD1 = WD;
            end else begin
                RD1 = rf[RA1];
            end
        end
    end

    always_comb begin
        RD2 = '0;
        if (ready && (RA2 != '0)) begin
            if (BYPASS && write_enable && (WA == RA2)) begin
                RD2 = WD;
            end else begin
                RD2 = rf[RA2];
            end
        end
    end

    // Committed contents only; the bypass path deliberately does not reach cpu_out.
    always_comb begin
        cpu_out = '0;
        if (ready && (OUT_ADDR != '0)) begin
            cpu_out = rf[OUT_ADDR];
        end
    end

endmodule
